// File: rtl/alsu_bist_pkg.sv
// rtl/alsu_bist_pkg.sv - shared FSM states, opcodes, LFSR step and vector field mapping for the ALSU BIST
package alsu_bist_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RST_PULSE = 3'd1,
        RAND      = 3'd2,
        SEQ       = 3'd3,
        TRANS     = 3'd4,
        DRAIN     = 3'd5,
        DONE      = 3'd6
    } state_e;

    localparam logic [2:0] OR     = 3'd0;
    localparam logic [2:0] XOR    = 3'd1;
    localparam logic [2:0] ADD    = 3'd2;
    localparam logic [2:0] MULT   = 3'd3;
    localparam logic [2:0] SHIFT  = 3'd4;
    localparam logic [2:0] ROTATE = 3'd5;
    localparam logic [2:0] INV6   = 3'd6;
    localparam logic [2:0] INV7   = 3'd7;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // One ALSU stimulus vector, as driven onto the ALSU input pins
    typedef struct packed {
        logic       dut_rst;
        logic [2:0] A;
        logic [2:0] B;
        logic [2:0] opcode;
        logic       cin;
        logic       serial_in;
        logic       direction;
        logic       red_op_A;
        logic       red_op_B;
        logic       bypass_A;
        logic       bypass_B;
    } stim_t;

    // Right-shifting Galois step, polynomial x^16+x^14+x^13+x^11+1
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

    // Fully random vector: reset 1/16, each bypass 1/8, any opcode including the invalid ones
    function automatic stim_t rand_vector(input logic [15:0] l);
        stim_t v;
        v.dut_rst   = (l[3:0] == 4'd0);
        v.A         = l[15:13];
        v.B         = l[5:3];
        v.opcode    = l[12:10];
        v.cin       = l[1];
        v.serial_in = l[7];
        v.direction = l[11];
        v.red_op_A  = l[14];
        v.red_op_B  = l[2];
        v.bypass_A  = (l[6:4] == 3'd0);
        v.bypass_B  = (l[9:7] == 3'd0);
        return v;
    endfunction

    // Operand draw for the directed phases: reset, bypass and reduction forced off
    function automatic stim_t held_vector(input logic [15:0] l, input logic [2:0] op);
        stim_t v;
        v           = '0;
        v.A         = l[15:13];
        v.B         = l[5:3];
        v.opcode    = op;
        v.cin       = l[1];
        v.serial_in = l[7];
        v.direction = l[11];
        return v;
    endfunction

endpackage

// File: rtl/alsu_bist_lfsr.sv
// rtl/alsu_bist_lfsr.sv - 16-bit Galois LFSR with seed reload and advance enable
module alsu_bist_lfsr
    import alsu_bist_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        adv_i,
    output logic [15:0] state_o
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    // Seed reload wins over advance so a new run always restarts the same stream
    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = SEED;
        end else if (adv_i) begin
            state_d = lfsr_step(state_q);
        end
    end

    // LFSR state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/alsu_bist_ctrl.sv
// rtl/alsu_bist_ctrl.sv - ALSU BIST stimulus generator and DUT/golden comparator; ALSU_BIST_COV_EN adds opcode coverage
module alsu_bist_ctrl
    import alsu_bist_pkg::*;
#(
    parameter int unsigned ITERATION = 1000,
    parameter int unsigned LAT       = 2,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        dut_rst,
    output logic [2:0]  A,
    output logic [2:0]  B,
    output logic [2:0]  opcode,
    output logic        cin,
    output logic        serial_in,
    output logic        direction,
    output logic        red_op_A,
    output logic        red_op_B,
    output logic        bypass_A,
    output logic        bypass_B,
    input  logic [5:0]  out_dut,
    input  logic [5:0]  out_ref,
    input  logic [15:0] leds_dut,
    input  logic [15:0] leds_ref,
    output logic [15:0] error_count,
    output logic [15:0] correct_count,
    output logic [5:0]  cov_hit
`ifdef ALSU_BIST_COV_EN
    ,
    output logic        cov_trans
`endif
);

    localparam logic [15:0] ITER_LAST = 16'(ITERATION - 1);
    localparam logic [15:0] LAT_LAST  = 16'(LAT - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  j_q, j_d;
    logic [2:0]  km_q, km_d;
    stim_t       stim_q, stim_d;
    logic        vld_q, vld_d;
    logic [LAT-1:0] sr_q, sr_d;
    logic [15:0] err_q, err_d;
    logic [15:0] cor_q, cor_d;
    logic [15:0] lfsr_val;
    logic        lfsr_adv;
    logic        start_ok;
    logic [3:0]  op_sum;
    logic [2:0]  seq_op;
    logic        tail;
    logic        mism;

    assign start_ok = start && ((state_q == IDLE) || (state_q == DONE));

    alsu_bist_lfsr #(.SEED(SEED)) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (start_ok),
        .adv_i   (lfsr_adv),
        .state_o (lfsr_val)
    );

    // Phase sequencing: cnt is the iteration/k/index counter, j the step inside a SEQ group, km = k mod 6
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        j_d     = j_q;
        km_d    = km_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RST_PULSE;
                    cnt_d   = '0;
                    j_d     = '0;
                    km_d    = '0;
                end
            end
            RST_PULSE: begin
                state_d = RAND;
                cnt_d   = '0;
            end
            RAND: begin
                if (cnt_q == ITER_LAST) begin
                    state_d = SEQ;
                    cnt_d   = '0;
                    j_d     = '0;
                    km_d    = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            SEQ: begin
                if (j_q == 3'd5) begin
                    j_d = '0;
                    if (cnt_q == ITER_LAST) begin
                        state_d = TRANS;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                        km_d  = (km_q == 3'd5) ? 3'd0 : km_q + 3'd1;
                    end
                end else begin
                    j_d = j_q + 3'd1;
                end
            end
            TRANS: begin
                if (cnt_q == 16'd5) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DRAIN: begin
                if (cnt_q == LAT_LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Load the vector belonging to the cycle being entered; DRAIN/DONE/IDLE keep the last vector untagged
    always_comb begin
        stim_d   = stim_q;
        vld_d    = 1'b0;
        lfsr_adv = 1'b0;
        op_sum   = {1'b0, km_d} + {1'b0, j_d};
        seq_op   = (op_sum >= 4'd6) ? 3'(op_sum - 4'd6) : op_sum[2:0];
        case (state_d)
            RST_PULSE: begin
                stim_d         = '0;
                stim_d.dut_rst = 1'b1;
                vld_d          = 1'b1;
            end
            RAND: begin
                stim_d   = rand_vector(lfsr_val);
                vld_d    = 1'b1;
                lfsr_adv = 1'b1;
            end
            SEQ: begin
                vld_d = 1'b1;
                if (j_d == 3'd0) begin
                    stim_d   = held_vector(lfsr_val, seq_op);
                    lfsr_adv = 1'b1;
                end else begin
                    stim_d.opcode = seq_op;
                end
            end
            TRANS: begin
                stim_d   = held_vector(lfsr_val, cnt_d[2:0]);
                vld_d    = 1'b1;
                lfsr_adv = 1'b1;
            end
            default: ;
        endcase
    end

    // Tag pipeline and saturating tallies; the tail lines up with the ALSU output of that vector
    always_comb begin
        sr_d[0] = vld_q;
        for (int i = 1; i < int'(LAT); i++) begin
            sr_d[i] = sr_q[i-1];
        end
        tail  = sr_q[LAT-1];
        mism  = ({out_dut, leds_dut} != {out_ref, leds_ref});
        err_d = err_q;
        cor_d = cor_q;
        if (start_ok) begin
            err_d = '0;
            cor_d = '0;
        end else if (tail) begin
            if (mism) begin
                if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
            end else begin
                if (cor_q != 16'hFFFF) cor_d = cor_q + 16'd1;
            end
        end
    end

    // Controller registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            j_q     <= '0;
            km_q    <= '0;
            stim_q  <= '0;
            vld_q   <= 1'b0;
            sr_q    <= '0;
            err_q   <= '0;
            cor_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            j_q     <= j_d;
            km_q    <= km_d;
            stim_q  <= stim_d;
            vld_q   <= vld_d;
            sr_q    <= sr_d;
            err_q   <= err_d;
            cor_q   <= cor_d;
        end
    end

`ifdef ALSU_BIST_COV_EN
    logic [LAT-1:0][2:0] cop_q;
    logic [LAT-1:0]      cum_q;
    logic [5:0]          cov_q, cov_d;
    logic [2:0]          prog_q, prog_d;
    logic                ctr_q, ctr_d;
    logic [2:0]          tail_op;

    assign tail_op = cop_q[LAT-1];

    // Carry each vector's opcode and unmasked flag alongside its valid tag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cop_q <= '0;
            cum_q <= '0;
        end else begin
            cop_q[0] <= stim_q.opcode;
            cum_q[0] <= ~(stim_q.dut_rst | stim_q.bypass_A | stim_q.bypass_B);
            for (int i = 1; i < int'(LAT); i++) begin
                cop_q[i] <= cop_q[i-1];
                cum_q[i] <= cum_q[i-1];
            end
        end
    end

    // Opcode hit bits and tracking of an in-order 0..5 run in the compared stream
    always_comb begin
        cov_d  = cov_q;
        prog_d = prog_q;
        ctr_d  = ctr_q;
        if (start_ok) begin
            cov_d  = '0;
            prog_d = '0;
            ctr_d  = 1'b0;
        end else if (tail) begin
            if (cum_q[LAT-1] && (tail_op < INV6)) begin
                cov_d[tail_op] = 1'b1;
            end
            if (tail_op == prog_q) begin
                if (prog_q == ROTATE) begin
                    ctr_d  = 1'b1;
                    prog_d = '0;
                end else begin
                    prog_d = prog_q + 3'd1;
                end
            end else if (tail_op == OR) begin
                prog_d = 3'd1;
            end else begin
                prog_d = '0;
            end
        end
    end

    // Coverage registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cov_q  <= '0;
            prog_q <= '0;
            ctr_q  <= 1'b0;
        end else begin
            cov_q  <= cov_d;
            prog_q <= prog_d;
            ctr_q  <= ctr_d;
        end
    end

    assign cov_hit   = cov_q;
    assign cov_trans = ctr_q;
`else
    assign cov_hit = 6'b0;
`endif

    assign busy          = (state_q != IDLE) && (state_q != DONE);
    assign done          = (state_q == DONE);
    assign pass          = done && (err_q == 16'd0);
    assign error_count   = err_q;
    assign correct_count = cor_q;
    assign dut_rst       = stim_q.dut_rst;
    assign A             = stim_q.A;
    assign B             = stim_q.B;
    assign opcode        = stim_q.opcode;
    assign cin           = stim_q.cin;
    assign serial_in     = stim_q.serial_in;
    assign direction     = stim_q.direction;
    assign red_op_A      = stim_q.red_op_A;
    assign red_op_B      = stim_q.red_op_B;
    assign bypass_A      = stim_q.bypass_A;
    assign bypass_B      = stim_q.bypass_B;

endmodule

// File: tb/tb_alsu_bist_ctrl.sv
// tb/tb_alsu_bist_ctrl.sv - scoreboard bench for alsu_bist_ctrl against a phase-level stimulus model
module tb_alsu_bist_ctrl;

    localparam int          IT   = 4;
    localparam int          LATT = 2;
    localparam int          N    = 1 + 7 * IT + 6;
    localparam logic [15:0] SD   = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        busy, done, pass, dut_rst;
    logic [2:0]  A, B, opcode;
    logic        cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B;
    logic [5:0]  out_dut, out_ref;
    logic [15:0] leds_dut, leds_ref;
    logic [15:0] error_count, correct_count;
    logic [5:0]  cov_hit;
`ifdef ALSU_BIST_COV_EN
    logic        cov_trans;
`endif

    logic [5:0]  o_val;
    logic [15:0] l_val;
    logic        inj;
    logic [16:0] dut_vec;
    logic [16:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          vec_idx  = 0;

    assign out_dut  = o_val;
    assign out_ref  = o_val;
    assign leds_ref = l_val;
    assign leds_dut = l_val ^ {15'b0, inj};
    assign dut_vec  = {dut_rst, A, B, opcode, cin, serial_in, direction,
                       red_op_A, red_op_B, bypass_A, bypass_B};

    alsu_bist_ctrl #(.ITERATION(IT), .LAT(LATT), .SEED(SD)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .dut_rst       (dut_rst),
        .A             (A),
        .B             (B),
        .opcode        (opcode),
        .cin           (cin),
        .serial_in     (serial_in),
        .direction     (direction),
        .red_op_A      (red_op_A),
        .red_op_B      (red_op_B),
        .bypass_A      (bypass_A),
        .bypass_B      (bypass_B),
        .out_dut       (out_dut),
        .out_ref       (out_ref),
        .leds_dut      (leds_dut),
        .leds_ref      (leds_ref),
        .error_count   (error_count),
        .correct_count (correct_count),
        .cov_hit       (cov_hit)
`ifdef ALSU_BIST_COV_EN
        ,
        .cov_trans     (cov_trans)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [15:0] step(input logic [15:0] s);
        int v;
        v = int'(s) >> 1;
        if (s[0]) v = v ^ 'hB400;
        return 16'(v);
    endfunction

    function automatic logic [16:0] pack(input int r, input int a, input int b, input int op,
                                         input int ci, input int si, input int di,
                                         input int ra, input int rb, input int ba, input int bb);
        logic [16:0] v;
        v = {1'(r), 3'(a), 3'(b), 3'(op), 1'(ci), 1'(si), 1'(di),
             1'(ra), 1'(rb), 1'(ba), 1'(bb)};
        return v;
    endfunction

    function automatic logic [16:0] rnd_vec(input logic [15:0] l);
        int v;
        v = int'(l);
        return pack(int'((v % 16) == 0), (v / 8192) % 8, (v / 8) % 8, (v / 1024) % 8,
                    (v / 2) % 2, (v / 128) % 2, (v / 2048) % 2, (v / 16384) % 2, (v / 4) % 2,
                    int'(((v / 16) % 8) == 0), int'(((v / 128) % 8) == 0));
    endfunction

    function automatic logic [16:0] dir_vec(input logic [15:0] l, input int op);
        int v;
        v = int'(l);
        return pack(0, (v / 8192) % 8, (v / 8) % 8, op, (v / 2) % 2, (v / 128) % 2,
                    (v / 2048) % 2, 0, 0, 0, 0);
    endfunction

    // Expected vector stream of one run, built phase by phase from the seed
    task automatic push_run();
        logic [15:0] l;
        logic [15:0] g;
        l = SD;
        exp_q.push_back(pack(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < IT; i++) begin
            exp_q.push_back(rnd_vec(l));
            l = step(l);
        end
        for (int k = 0; k < IT; k++) begin
            g = l;
            l = step(l);
            for (int j = 0; j < 6; j++) exp_q.push_back(dir_vec(g, (k + j) % 6));
        end
        for (int t = 0; t < 6; t++) begin
            exp_q.push_back(dir_vec(l, t));
            l = step(l);
        end
    endtask

    // Monitor: every busy cycle presents the next expected vector until the run's vectors are used up
    always @(negedge clk) begin
        if (busy && exp_q.size() > 0) begin
            check($sformatf("vec%0d", vec_idx), 32'(dut_vec), 32'(exp_q.pop_front()));
            vec_idx++;
        end
    end

    task automatic cov_checks();
`ifdef ALSU_BIST_COV_EN
        check("cov_hit", 32'(cov_hit), 32'h3F);
        check("cov_trans", 32'(cov_trans), 32'd1);
`else
        check("cov_hit", 32'(cov_hit), 32'h0);
`endif
    endtask

    task automatic do_run(input int ia, input int ib, input int ic, input int abort_at);
        int n_inj;
        n_inj   = int'(ia >= 0) + int'(ib >= 0) + int'(ic >= 0);
        vec_idx = 0;
        push_run();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("cleared_err", 32'(error_count), 32'd0);
        check("cleared_cor", 32'(correct_count), 32'd0);
        for (int m = 0; m <= N + LATT; m++) begin
            o_val = 6'($urandom);
            l_val = 16'($urandom);
            inj   = (m >= LATT) && ((m - LATT) == ia || (m - LATT) == ib || (m - LATT) == ic);
            if (m == 10) start = 1'b1;
            if (m == 11) start = 1'b0;
            if (m == abort_at) begin
                rst_n = 1'b0;
                #1;
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_err", 32'(error_count), 32'd0);
                check("abort_cor", 32'(correct_count), 32'd0);
                check("abort_stim", 32'(dut_vec), 32'd0);
                exp_q.delete();
                inj = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (m == N + LATT - 1) check("done_early", 32'({done, busy}), 32'b01);
            if (m == N + LATT) check("done_edge", 32'({done, busy}), 32'b10);
            if (m < N + LATT) begin
                @(posedge clk);
                #1;
            end
        end
        inj = 1'b0;
        check("err_count", 32'(error_count), 32'(n_inj));
        check("cor_count", 32'(correct_count), 32'(N - n_inj));
        check("pass", 32'(pass), 32'(n_inj == 0));
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        cov_checks();
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        inj   = 1'b0;
        o_val = '0;
        l_val = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_flags", 32'({busy, done, pass}), 32'd0);
        check("rst_stim", 32'(dut_vec), 32'd0);
        check("rst_counts", 32'({error_count, correct_count}), 32'd0);
        check("rst_cov", 32'(cov_hit), 32'd0);

        do_run(-1, -1, -1, -1);
        do_run(0, 17, N - 1, -1);
        do_run(-1, -1, -1, 3);
        repeat (2) @(posedge clk);
        #1;
        check("idle_after_abort", 32'({busy, done}), 32'd0);
        do_run(-1, -1, -1, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
